// File: rtl/cram_loader.sv
// cram_loader: serialises configuration words MSB-first into the CRAM scan
// chain (cram_sdi/cram_shift), stopping after exactly CHAIN_LEN shifts.
// Optional feature macro: CRAM_READBACK_EN adds a recirculating readback pass
// that compares a CRC-16-CCITT of the loaded stream with one of the chain tail.

module cram_loader #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned CHAIN_LEN  = 64,
  parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cram_sdi,
  output logic                  cram_shift,
  input  logic                  cram_sdo,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned REM_W = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W:0] ChainLenW = (CNT_W + 1)'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);

`ifdef CRAM_READBACK_EN
  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic                  sdi_q, sdi_d;
  logic                  shift_q, shift_d;

  logic [CNT_W:0] issued;
  logic           room;
  logic           last_shift;

  // Shifts already done plus the one on the wire this cycle; new shifts only while below CHAIN_LEN.
  assign issued     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, shift_q};
  assign room       = issued < ChainLenW;
  assign last_shift = shift_q && (cnt_q == LastCnt);

`ifdef CRAM_READBACK_EN
  logic [15:0] crc_ld_q, crc_ld_d;
  logic [15:0] crc_rb_q, crc_rb_d;
  logic        err_q, err_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    rem_d      = rem_q;
    sdi_d      = 1'b0;
    shift_d    = 1'b0;
    word_ready = 1'b0;
`ifdef CRAM_READBACK_EN
    crc_ld_d   = crc_ld_q;
    crc_rb_d   = crc_rb_q;
    err_d      = err_q;
`endif
    if (shift_q) cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
          buf_d   = '0;
          rem_d   = '0;
`ifdef CRAM_READBACK_EN
          crc_ld_d = 16'hFFFF;
          crc_rb_d = 16'hFFFF;
          err_d    = 1'b0;
`endif
        end
      end
      StLoad: begin
`ifdef CRAM_READBACK_EN
        if (shift_q) crc_ld_d = crc_step(crc_ld_q, sdi_q);
`endif
        // Ready while the last buffered bit is on the wire gives zero-bubble streaming.
        word_ready = (rem_q == '0) && room;
        if (room) begin
          if (rem_q != '0) begin
            shift_d = 1'b1;
            sdi_d   = buf_q[WORD_WIDTH-1];
            buf_d   = buf_q << 1;
            rem_d   = rem_q - REM_W'(1);
          end else if (word_valid) begin
            shift_d = 1'b1;
            sdi_d   = word_data[WORD_WIDTH-1];
            buf_d   = word_data << 1;
            rem_d   = REM_W'(WORD_WIDTH - 1);
          end
        end
        // Leftover low-order bits of the final word are dropped here.
        if (last_shift) begin
          rem_d = '0;
`ifdef CRAM_READBACK_EN
          state_d = StVerify;
          cnt_d   = '0;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CRAM_READBACK_EN
      StVerify: begin
        if (shift_q) crc_rb_d = crc_step(crc_rb_q, cram_sdo);
        shift_d = room;
        if (last_shift) begin
          state_d = StDone;
          err_d   = (crc_ld_q != crc_rb_d);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and registered chain outputs; synchronous reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      sdi_q   <= 1'b0;
      shift_q <= 1'b0;
`ifdef CRAM_READBACK_EN
      crc_ld_q <= 16'hFFFF;
      crc_rb_q <= 16'hFFFF;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      sdi_q   <= sdi_d;
      shift_q <= shift_d;
`ifdef CRAM_READBACK_EN
      crc_ld_q <= crc_ld_d;
      crc_rb_q <= crc_rb_d;
      err_q    <= err_d;
`endif
    end
  end

  assign cram_shift = shift_q;
  assign done       = (state_q == StDone);

`ifdef CRAM_READBACK_EN
  // Recirculate the tail straight back into the head so verify leaves contents intact.
  assign cram_sdi = (state_q == StVerify) ? cram_sdo : sdi_q;
  assign busy     = (state_q == StLoad) || (state_q == StVerify);
  assign error    = err_q;
`else
  logic unused_sdo;
  assign unused_sdo = cram_sdo;
  assign cram_sdi   = sdi_q;
  assign busy       = (state_q == StLoad);
  assign error      = 1'b0;
`endif

endmodule

// File: doc/cram_loader.md
Name: cram_loader

Overview:
- Bitstream writer for the CRAM configuration scan chain formed by daisy-chained fpgacell tiles.
- Accepts configuration words from a host-side source over a valid/ready handshake.
- Serializes the words one bit per clock into the head of the chain (config_data_in of the first cell) and drives the chain's shift enable (config_en).
- Observes the chain tail (config_data_out of the last cell) for optional non-destructive readback verification.

Parameters:
- WORD_WIDTH, 8, width of each input configuration word.
- CHAIN_LEN, 64, total CRAM bits in the chain (sum over all tiles); must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- clk  input  1  system/config clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a load; sampled only in IDLE/DONE.
- word_data  input  WORD_WIDTH  configuration word, MSB shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word_data this cycle.
- cram_sdi  output  1  serial data to chain head (config_data_in).
- cram_shift  output  1  chain shift enable (config_en); one chain shift per high cycle.
- cram_sdo  input  1  serial data from chain tail (config_data_out).
- busy  output  1  load or verify in progress.
- done  output  1  level; last load complete; cleared by start or rst.
- error  output  1  level; readback CRC mismatch; tied 0 when CRAM_READBACK_EN is undefined.

Behaviour:
- Reset (clk edge with rst=1) has priority over all other events:
  - State goes to IDLE.
  - word_ready, cram_sdi, cram_shift, busy, done and error are all 0.
  - The bit counter and shift buffer clear.
  - Reset during LOAD or VERIFY aborts the operation; chain contents are undefined and the chain must be reloaded.
- Chain contract: the chain is a pure shift register. After N shifts, the bit shifted first is visible on cram_sdo.
- States: IDLE, LOAD, VERIFY (optional), DONE.
- IDLE/DONE:
  - start=1 -> LOAD next cycle; done and error clear; bit counter = 0.
  - start while busy is ignored.
- LOAD, shift buffer holds WORD_WIDTH bits plus a remaining-bit count:
  - word_ready=1 when the buffer is empty, or when the buffer is shifting its last bit this cycle. This gives zero-bubble streaming.
  - A word is accepted on the cycle word_valid && word_ready.
  - The first bit of the accepted word drives cram_sdi with cram_shift=1 in the following cycle.
  - cram_sdi and cram_shift are registered outputs.
  - Buffer empty and no word accepted -> cram_shift=0; the chain holds its state (stall; no limit on stall length).
  - Each cram_shift=1 cycle increments the bit counter.
  - When the counter reaches CHAIN_LEN, word_ready drops. Any remaining low-order bits of the final word are discarded and not shifted.
  - Total words consumed = ceil(CHAIN_LEN/WORD_WIDTH); no extra word is accepted.
  - Cycle after the CHAIN_LEN-th shift: go to DONE (or to VERIFY if enabled); cram_shift=0.
- busy=1 in LOAD and VERIFY only.
- done=1 in DONE only; it rises the cycle after the final shift (macro off) or after the final verify shift (macro on).
- word_valid while not in LOAD: ignored; word_ready stays 0.
- Counter: never exceeds CHAIN_LEN; no wrap.

Optional Feature:
- Macro: CRAM_READBACK_EN.
- Defined:
  - During LOAD, a bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) is updated with each shifted bit.
  - In VERIFY, drive cram_shift=1 for exactly CHAIN_LEN consecutive cycles with cram_sdi = cram_sdo (recirculate). This leaves chain contents unchanged.
  - A second CRC (same init) is updated with each cram_sdo bit.
  - Next cycle: go to DONE; error = (crc_load != crc_readback).
- Undefined: no VERIFY state; LOAD goes directly to DONE; error is constant 0; no CRC logic.

Test Plan:
- WORD_WIDTH=8, CHAIN_LEN=20; start, words 0xA5, 0x3C, 0xF0 back-to-back -> cram_shift high for exactly 20 consecutive cycles; sdi sequence = 1010_0101_0011_1100_1111; 3 words accepted; done=1 the cycle after the last shift (macro off); chain model holds the bits in order.
- Same stream with word_valid low for 5 cycles between words 1 and 2 -> cram_shift low for those cycles; identical 20-bit sequence; counter holds at 8 during the stall.
- start pulsed mid-LOAD, and a 4th word presented after the 3rd -> start ignored; the 4th word is not accepted (word_ready=0); busy drops only after 20 shifts.
- rst asserted after 10 shifts -> next cycle all outputs 0, state IDLE; a new start reloads from bit 0 with a full 20 shifts.
- CRAM_READBACK_EN, CHAIN_LEN=20, ideal chain model -> 20 load shifts then 20 recirculate shifts; chain contents unchanged; done=1, error=0.
- CRAM_READBACK_EN, chain model flips one stored bit before VERIFY -> done=1, error=1.
